// File: rtl/pipe_trace_pkg.sv
// pipe_trace_pkg: shared types and helpers for the pipeline trace buffer.
package pipe_trace_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_NUM_CH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  // Bit offset of channel k inside a packed sample of w-bit channels.
  function automatic int unsigned ch_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/pipe_trace_buffer_trace_ram.sv
// trace_ram: simple dual-port RAM, one write port and one registered read port.
// The read register resets to zero so the read data is defined after reset.
module trace_ram #(
  parameter int unsigned W     = 128,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: on-chip logic analyser capturing NUM_CH debug words per
// cycle into a circular window, frozen a programmable number of samples after
// a trigger and then read out through a request/valid port.
// Optional: define TRACE_TIMESTAMP_EN to store a 32-bit cycle stamp per sample
// and expose it on rd_ts.
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter  int unsigned DATA_W = DEF_DATA_W,
  parameter  int unsigned NUM_CH = DEF_NUM_CH,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned AW     = $clog2(DEPTH)
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     sample_en,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     trig_ext,
  input  logic [DATA_W-1:0]        trig_val,
  input  logic [DATA_W-1:0]        trig_mask,
  input  logic [AW-1:0]            post_cnt,
  input  logic                     rd_req,
  input  logic [AW-1:0]            rd_addr,
  output logic                     rd_valid,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic [1:0]               state_o,
  output logic [AW-1:0]            trig_pos,
  output logic [AW:0]              fill
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]              rd_ts
`endif
);

  localparam int unsigned SW = NUM_CH * DATA_W;
`ifdef TRACE_TIMESTAMP_EN
  localparam int unsigned RW = SW + 32;
`else
  localparam int unsigned RW = SW;
`endif
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  trace_state_e  state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [AW-1:0] post_q, post_d;
  logic [AW-1:0] remain_q, remain_d;
  logic [AW-1:0] trig_abs_q, trig_abs_d;
  logic          rd_valid_q;
  logic          we, re;
  logic          trig_hit;
  logic [DATA_W-1:0] ch0;
  logic [AW-1:0] oldest, rd_ptr;
  logic [RW-1:0] wdata, rdata;

  assign ch0      = ch_data[ch_lsb(0, DATA_W) +: DATA_W];
  assign trig_hit = trig_ext |
                    ((trig_mask != '0) && ((ch0 & trig_mask) == (trig_val & trig_mask)));

  // A full window has fill = DEPTH whose low AW bits are zero, so oldest = wptr.
  assign oldest   = wptr_q - fill_q[AW-1:0];
  assign rd_ptr   = oldest + rd_addr;
  assign trig_pos = trig_abs_q - oldest;
  assign fill     = fill_q;
  assign state_o  = state_q;
  assign rd_valid = rd_valid_q;

  // Next-state, pointer and write/read enables.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    fill_d     = fill_q;
    post_d     = post_q;
    remain_d   = remain_q;
    trig_abs_d = trig_abs_q;
    we         = 1'b0;
    re         = 1'b0;
    if (arm) begin
      // Arm restarts from any state and suppresses capture, trigger and read.
      state_d    = ST_ARMED;
      wptr_d     = '0;
      fill_d     = '0;
      post_d     = post_cnt;
      remain_d   = '0;
      trig_abs_d = '0;
    end else begin
      unique case (state_q)
        ST_ARMED, ST_POST: begin
          if (sample_en) begin
            we     = 1'b1;
            wptr_d = wptr_q + 1'b1;
            if (fill_q != FULL) fill_d = fill_q + 1'b1;
            if (state_q == ST_ARMED) begin
              if (trig_hit) begin
                trig_abs_d = wptr_q;
                if (post_q == '0) begin
                  state_d = ST_DONE;
                end else begin
                  state_d  = ST_POST;
                  remain_d = post_q;
                end
              end
            end else begin
              remain_d = remain_q - 1'b1;
              if (remain_q == AW'(1)) state_d = ST_DONE;
            end
          end
        end
        ST_DONE: re = rd_req;
        default: ;
      endcase
    end
  end

  // State and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      fill_q     <= '0;
      post_q     <= '0;
      remain_q   <= '0;
      trig_abs_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      fill_q     <= fill_d;
      post_q     <= post_d;
      remain_q   <= remain_d;
      trig_abs_q <= trig_abs_d;
      rd_valid_q <= re;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;

  // Free-running cycle counter stamped onto every stored sample.
  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 32'd1;
  end

  assign wdata   = {ts_q, ch_data};
  assign rd_data = rdata[SW-1:0];
  assign rd_ts   = rdata[SW +: 32];
`else
  assign wdata   = ch_data;
  assign rd_data = rdata;
`endif

  trace_ram #(
    .W     (RW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wptr_q),
    .wdata (wdata),
    .re    (re),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb_pipe_trace_buffer: randomized and directed checks of pipe_trace_buffer
// against a queue-based window model. Honours TRACE_TIMESTAMP_EN.
module tb_pipe_trace_buffer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AW     = 4;
  localparam int unsigned TW     = NUM_CH * DATA_W;

  logic              clk = 1'b0;
  logic              rst, arm, sample_en, trig_ext, rd_req;
  logic [TW-1:0]     ch_data;
  logic [DATA_W-1:0] trig_val, trig_mask;
  logic [AW-1:0]     post_cnt, rd_addr;
  logic              rd_valid;
  logic [TW-1:0]     rd_data;
  logic [1:0]        state_o;
  logic [AW-1:0]     trig_pos;
  logic [AW:0]       fill;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]       rd_ts;
`endif

  pipe_trace_buffer #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .sample_en (sample_en),
    .ch_data   (ch_data),
    .trig_ext  (trig_ext),
    .trig_val  (trig_val),
    .trig_mask (trig_mask),
    .post_cnt  (post_cnt),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .state_o   (state_o),
    .trig_pos  (trig_pos),
    .fill      (fill)
`ifdef TRACE_TIMESTAMP_EN
    ,
    .rd_ts     (rd_ts)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: the window is the list of the last DEPTH stored samples.
  int            m_state = 0;   // 0 idle, 1 armed, 2 post, 3 done
  logic [TW-1:0] m_q[$];
  logic [31:0]   m_tq[$];
  int            m_trig = 0;    // index of trigger sample within m_q
  int            m_remain = 0;
  int            m_post = 0;
  bit            m_rv, m_chk, m_rst_chk;
  logic [TW-1:0] m_exp;
  logic [31:0]   m_exp_ts;
  logic [31:0]   m_cyc = '0;

  task automatic check_val(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_tick();
    logic        hit;
    logic [31:0] cyc_now;
    cyc_now   = m_cyc;
    m_rv      = 1'b0;
    m_chk     = 1'b0;
    m_rst_chk = 1'b0;
    hit = trig_ext ||
          ((trig_mask != 0) && ((ch_data[DATA_W-1:0] & trig_mask) == (trig_val & trig_mask)));
    if (rst) begin
      m_state = 0;
      m_q.delete();
      m_tq.delete();
      m_rst_chk = 1'b1;
    end else if (arm) begin
      m_state = 1;
      m_q.delete();
      m_tq.delete();
      m_post = int'(post_cnt);
    end else if ((m_state == 1 || m_state == 2) && sample_en) begin
      m_q.push_back(ch_data);
      m_tq.push_back(cyc_now);
      if (m_q.size() > DEPTH) begin
        void'(m_q.pop_front());
        void'(m_tq.pop_front());
        m_trig--;
      end
      if (m_state == 1) begin
        if (hit) begin
          m_trig = m_q.size() - 1;
          if (m_post == 0) m_state = 3;
          else begin
            m_state  = 2;
            m_remain = m_post;
          end
        end
      end else begin
        m_remain--;
        if (m_remain == 0) m_state = 3;
      end
    end else if (m_state == 3 && rd_req) begin
      m_rv = 1'b1;
      if (int'(rd_addr) < m_q.size()) begin
        m_chk    = 1'b1;
        m_exp    = m_q[rd_addr];
        m_exp_ts = m_tq[rd_addr];
      end
    end
    m_cyc = rst ? 32'd0 : m_cyc + 32'd1;
  endtask

  // One clock: update model at the edge, compare #1 later.
  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    check_val("state", TW'(state_o), TW'(m_state));
    check_val("fill", TW'(fill), TW'(m_q.size()));
    if (m_state == 3) check_val("trig_pos", TW'(trig_pos), TW'(m_trig));
    check_val("rd_valid", TW'(rd_valid), TW'(m_rv));
    if (m_rv && m_chk) begin
      check_val("rd_data", rd_data, m_exp);
`ifdef TRACE_TIMESTAMP_EN
      check_val("rd_ts", TW'(rd_ts), TW'(m_exp_ts));
`endif
    end
    if (m_rst_chk) check_val("rd_data_rst", rd_data, '0);
  endtask

  task automatic quiet();
    rst = 1'b0; arm = 1'b0; sample_en = 1'b0; trig_ext = 1'b0; rd_req = 1'b0;
  endtask

  task automatic rand_data(input logic [31:0] c0);
    ch_data = {$urandom, $urandom, $urandom, c0};
  endtask

  task automatic do_arm(input int post);
    quiet();
    post_cnt = AW'(post);
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic read_window();
    for (int a = 0; a < int'(DEPTH); a++) begin
      rd_req  = 1'b1;
      rd_addr = AW'(a);
      step();
    end
    rd_req = 1'b0;
    step();
  endtask

  initial begin
    logic [31:0] ts0;
    logic [31:0] val;
    int          k;
    quiet();
    trig_val = '0; trig_mask = '0; post_cnt = '0; rd_addr = '0; ch_data = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_val("reset_state", TW'(state_o), '0);
    check_val("reset_fill", TW'(fill), '0);

    // 1: counting ch0, compare trigger on 20, post 4.
    trig_mask = '1; trig_val = 32'd20;
    do_arm(4);
    for (int i = 0; i < 25; i++) begin
      sample_en = 1'b1;
      rand_data(32'(i));
      step();
    end
    sample_en = 1'b0;
    check_val("t1_state", TW'(state_o), TW'(3));
    check_val("t1_fill", TW'(fill), TW'(16));
    check_val("t1_trig_pos", TW'(trig_pos), TW'(11));
    rd_req = 1'b1; rd_addr = 4'd0;
    step();
    val = rd_data[31:0];
    check_val("t1_rd0", TW'(val), TW'(9));
    rd_addr = 4'd15;
    step();
    val = rd_data[31:0];
    check_val("t1_rd15", TW'(val), TW'(24));
    rd_req = 1'b0;
    step();

    // 2: post 0, external trigger on the third sample.
    trig_mask = '0;
    do_arm(0);
    for (int i = 0; i < 6; i++) begin
      sample_en = 1'b1;
      trig_ext  = (i == 2);
      rand_data($urandom);
      step();
      if (i == 2) begin
        check_val("t2_state", TW'(state_o), TW'(3));
        check_val("t2_fill", TW'(fill), TW'(3));
        check_val("t2_trig_pos", TW'(trig_pos), TW'(2));
      end
    end
    quiet();
    check_val("t2_fill_hold", TW'(fill), TW'(3));
    read_window();

    // 3: alternate sample_en, unqualified trigger ignored.
    do_arm(2);
    for (int i = 0; i < 12; i++) begin
      sample_en = (i % 2 == 0);
      trig_ext  = (i == 5) || (i == 6);
      rand_data($urandom);
      step();
      if (i == 5) check_val("t3_unqualified", TW'(state_o), TW'(1));
    end
    quiet();
    check_val("t3_state", TW'(state_o), TW'(3));
    check_val("t3_fill", TW'(fill), TW'(6));
    check_val("t3_trig_pos", TW'(trig_pos), TW'(3));
    read_window();

    // 4: reset while in POST.
    do_arm(5);
    for (int i = 0; i < 3; i++) begin
      sample_en = 1'b1;
      trig_ext  = (i == 1);
      rand_data($urandom);
      step();
    end
    quiet();
    check_val("t4_post", TW'(state_o), TW'(2));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("t4_state", TW'(state_o), '0);
    check_val("t4_fill", TW'(fill), '0);
    rd_req = 1'b1;
    step();
    check_val("t4_rd_valid", TW'(rd_valid), '0);
    rd_req = 1'b0;

    // 5: re-arm in POST, then a new window.
    do_arm(3);
    for (int i = 0; i < 4; i++) begin
      sample_en = 1'b1;
      trig_ext  = (i == 2);
      rand_data($urandom);
      step();
    end
    quiet();
    post_cnt = 4'd2;
    arm = 1'b1;
    trig_ext = 1'b1;
    sample_en = 1'b1;
    step();
    quiet();
    check_val("t5_state", TW'(state_o), TW'(1));
    check_val("t5_fill", TW'(fill), '0);
    for (int i = 0; i < 7; i++) begin
      sample_en = 1'b1;
      trig_ext  = (i == 3);
      rand_data($urandom);
      step();
    end
    quiet();
    check_val("t5_done", TW'(state_o), TW'(3));
    check_val("t5_trig_pos", TW'(trig_pos), TW'(3));
    read_window();

`ifdef TRACE_TIMESTAMP_EN
    // 6: stalls between samples are visible in the stamps.
    do_arm(2);
    for (int i = 0; i < 15; i++) begin
      sample_en = (i % 3 == 0);
      trig_ext  = (i == 6);
      rand_data($urandom);
      step();
    end
    quiet();
    rd_req = 1'b1; rd_addr = 4'd0;
    step();
    ts0 = rd_ts;
    rd_addr = 4'd1;
    step();
    check_val("t6_ts_delta", TW'(rd_ts - ts0), TW'(3));
    rd_req = 1'b0;
    step();
`else
    ts0 = '0;
`endif

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      trig_val  = 32'($urandom_range(0, 63));
      trig_mask = ($urandom_range(0, 1) == 1) ? 32'h3f : 32'h0;
      do_arm($urandom_range(0, DEPTH - 1));
      k = 0;
      while (m_state != 3 && k < 300) begin
        quiet();
        sample_en = ($urandom_range(0, 9) < 7);
        trig_ext  = ($urandom_range(0, 39) == 0);
        arm       = ($urandom_range(0, 149) == 0) || (m_state == 0);
        rst       = ($urandom_range(0, 299) == 0);
        post_cnt  = AW'($urandom_range(0, DEPTH - 1));
        rand_data(32'($urandom_range(0, 63)));
        step();
        k++;
      end
      quiet();
      if (m_state == 3) begin
        if ($urandom_range(0, 3) == 0) begin
          rd_req = 1'b1;
          rd_addr = '0;
          arm = 1'b1;
          step();
          quiet();
        end else begin
          read_window();
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
